// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: paces NCH sensor channels with per-channel sample
// periods and shares a single external ADC among them. Due channels are
// granted round-robin, the converter is driven through a start/done
// handshake, and missed samples (overrun) and converter timeouts are flagged.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no conversion in flight; grant the next pending channel
// S_START | adc_start high for this single cycle
// S_WAIT  | waiting for adc_done, bounded by TIMEOUT cycles
// S_DONE  | sample_valid high for this single cycle
module adc_sample_scheduler #(
  parameter int NCH     = 4,
  parameter int CH_W    = 2,
  parameter int DIV_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             clear_flags,
  output logic             adc_start,
  output logic [CH_W-1:0]  adc_ch,
  input  logic             adc_done,
  output logic             sample_valid,
  output logic [CH_W-1:0]  sample_ch,
  output logic             busy,
  output logic [NCH-1:0]   overrun,
  output logic             adc_error
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q [NCH];
  logic [DIV_W-1:0] div_d [NCH];
  logic [DIV_W-1:0] cnt_q [NCH];
  logic [DIV_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   overrun_q, overrun_d;
  logic [NCH-1:0]   match, tick;
  logic [CH_W-1:0]  last_grant_q;
  logic [CH_W-1:0]  grant_idx;
  logic             grant_found;
  logic             grant_en;
  logic [TO_W-1:0]  to_cnt_q;
  logic             adc_start_q, sample_valid_q, busy_q, adc_error_q;
  logic [CH_W-1:0]  adc_ch_q, sample_ch_q;

  // Terminal-count detect per channel; compares cnt+1 against div so that
  // div-1 is never formed, and a config write on the channel suppresses it.
  always_comb begin
    match = '0;
    tick  = '0;
    for (int i = 0; i < NCH; i++) begin
      match[i] = (div_q[i] != '0) &&
                 (({1'b0, cnt_q[i]} + {{DIV_W{1'b0}}, 1'b1}) == {1'b0, div_q[i]});
      tick[i]  = enable && match[i] && !(cfg_we && (cfg_ch == CH_W'(i)));
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      if (!grant_found && pending_q[(int'(last_grant_q) + k) % NCH]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'((int'(last_grant_q) + k) % NCH);
      end
    end
  end

  assign grant_en = (state_q == S_IDLE) && enable && grant_found;

  // Next-state for period counters, pending and overrun flags.
  // Ordering matters: grant clear, then tick set, then config override.
  always_comb begin
    div_d     = div_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (clear_flags) begin
      overrun_d = '0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (grant_en && (grant_idx == CH_W'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (enable && (div_q[i] != '0)) begin
        cnt_d[i] = match[i] ? '0 : cnt_q[i] + {{(DIV_W-1){1'b0}}, 1'b1};
      end
      if (tick[i]) begin
        if (pending_q[i] && !(grant_en && (grant_idx == CH_W'(i)))) begin
          overrun_d[i] = 1'b1;
        end
        pending_d[i] = 1'b1;
      end
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        div_d[i]     = cfg_div;
        cnt_d[i]     = '0;
        pending_d[i] = 1'b0;
      end
    end
  end

  // Channel period/counter/pending registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        div_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Conversion sequencer with registered handshake and status outputs.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      last_grant_q   <= CH_W'(NCH - 1);
      to_cnt_q       <= '0;
      adc_start_q    <= 1'b0;
      adc_ch_q       <= '0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      busy_q         <= 1'b0;
      adc_error_q    <= 1'b0;
    end else begin
      adc_start_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      if (clear_flags) begin
        adc_error_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (grant_en) begin
            adc_ch_q     <= grant_idx;
            last_grant_q <= grant_idx;
            adc_start_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_START;
          end
        end
        S_START: begin
          to_cnt_q <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (adc_done) begin
            sample_ch_q    <= adc_ch_q;
            sample_valid_q <= 1'b1;
            state_q        <= S_DONE;
          end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            adc_error_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adc_start    = adc_start_q;
  assign adc_ch       = adc_ch_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign adc_error    = adc_error_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: a cycle table for the basic handshake,
// then hand-written sequences for round-robin, overrun, timeout,
// reconfiguration and asynchronous reset.
module tb_adc_sample_scheduler;
  localparam int NCH = 4, CH_W = 2, DIV_W = 32, TIMEOUT = 16;

  logic             clk_in = 1'b0;
  logic             reset, enable, cfg_we, clear_flags, adc_done;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             adc_start, sample_valid, busy, adc_error;
  logic [CH_W-1:0]  adc_ch, sample_ch;
  logic [NCH-1:0]   overrun;

  adc_sample_scheduler #(.NCH(NCH), .CH_W(CH_W), .DIV_W(DIV_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clear_flags(clear_flags),
    .adc_start(adc_start), .adc_ch(adc_ch), .adc_done(adc_done),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .busy(busy),
    .overrun(overrun), .adc_error(adc_error)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Observed start pulses (cycle, channel) and sample tags.
  int              st_cyc[$];
  logic [CH_W-1:0] st_ch[$];
  logic [CH_W-1:0] sv_ch[$];

  always @(negedge clk_in) begin
    if (adc_start) begin
      st_cyc.push_back(cyc);
      st_ch.push_back(adc_ch);
    end
    if (sample_valid) sv_ch.push_back(sample_ch);
  end

  // Converter model: adc_done pulses resp_delay cycles after adc_start.
  bit resp_en = 1'b0;
  int resp_delay = 3;
  int done_cnt = 0;

  initial forever begin
    @(negedge clk_in);
    if (resp_en) begin
      if (done_cnt > 0) begin
        done_cnt = done_cnt - 1;
        adc_done = (done_cnt == 0);
      end else begin
        adc_done = 1'b0;
      end
      if (adc_start) done_cnt = resp_delay;
    end
  end

  typedef struct {
    logic            en;
    logic            we;
    logic [CH_W-1:0] wch;
    logic [31:0]     wdiv;
    logic            done;
    logic            exp_start;
    logic [CH_W-1:0] exp_ch;
    logic            exp_valid;
    logic [CH_W-1:0] exp_sch;
    logic            exp_busy;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic en, input logic we, input int wch, input int wdiv,
                              input logic done, input logic xs, input int xch,
                              input logic xv, input int xsch, input logic xb);
    vec_t v;
    v.en = en; v.we = we; v.wch = CH_W'(wch); v.wdiv = 32'(wdiv); v.done = done;
    v.exp_start = xs; v.exp_ch = CH_W'(xch); v.exp_valid = xv;
    v.exp_sch = CH_W'(xsch); v.exp_busy = xb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b1; enable = 1'b0; cfg_we = 1'b0; clear_flags = 1'b0;
    resp_en = 1'b0; adc_done = 1'b0; done_cnt = 0;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    st_cyc.delete(); st_ch.delete(); sv_ch.delete();
  endtask

  task automatic cfg_write(input int ch, input int div);
    @(negedge clk_in);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_div = DIV_W'(div);
    @(negedge clk_in);
    cfg_we = 1'b0;
  endtask

  // Returns the number of the first edge that sees enable=1.
  task automatic start_en(output int e0);
    @(negedge clk_in);
    enable = 1'b1;
    @(negedge clk_in);
    e0 = cyc;
  endtask

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk_in);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk_in);
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1;
    reset = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    clear_flags = 1'b0; adc_done = 1'b0;

    tbl[0]  = mk(1, 1, 2, 4, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 2, 0, 0, 1);
    tbl[7]  = mk(1, 0, 0, 0, 1, 0, 2, 1, 2, 1);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 2, 0, 2, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 1, 2, 0, 2, 1);
    tbl[10] = mk(1, 0, 0, 0, 1, 0, 2, 0, 2, 1);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 2, 0, 2, 1);
    tbl[12] = mk(1, 0, 0, 0, 1, 0, 2, 1, 2, 1);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 2, 0, 2, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 1, 2, 0, 2, 1);

    // Reset state
    repeat (2) @(negedge clk_in);
    chk("rst_adc_start", 32'(adc_start), 32'd0);
    chk("rst_adc_ch", 32'(adc_ch), 32'd0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_sample_ch", 32'(sample_ch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_adc_error", 32'(adc_error), 32'd0);
    reset = 1'b0;

    // Cycle table: ch2 period 4, converter driven directly from the table
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_in);
      enable = tbl[i].en; cfg_we = tbl[i].we; cfg_ch = tbl[i].wch;
      cfg_div = tbl[i].wdiv; adc_done = tbl[i].done;
      @(posedge clk_in);
      #1;
      chk($sformatf("vec%0d_start", i), 32'(adc_start), 32'(tbl[i].exp_start));
      chk($sformatf("vec%0d_ch", i), 32'(adc_ch), 32'(tbl[i].exp_ch));
      chk($sformatf("vec%0d_valid", i), 32'(sample_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_sch", i), 32'(sample_ch), 32'(tbl[i].exp_sch));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      chk($sformatf("vec%0d_ovr", i), 32'(overrun), 32'd0);
      chk($sformatf("vec%0d_err", i), 32'(adc_error), 32'd0);
    end

    // Period and handshake: ch0 div=8, done 3 cycles after start
    do_reset();
    resp_delay = 3; resp_en = 1'b1;
    cfg_write(0, 8);
    start_en(e0);
    goto(e0 + 41);
    enable = 1'b0;
    wait_idle("A_idle", 20);
    chk("A_nstart", st_cyc.size(), 32'd5);
    for (int k = 0; k < st_cyc.size() && k < 5; k++) begin
      chk($sformatf("A_start%0d_cyc", k), st_cyc[k] - e0, 32'(8 * (k + 1)));
      chk($sformatf("A_start%0d_ch", k), 32'(st_ch[k]), 32'd0);
    end
    chk("A_nvalid", sv_ch.size(), 32'd5);
    for (int k = 0; k < sv_ch.size() && k < 5; k++)
      chk($sformatf("A_valid%0d_ch", k), 32'(sv_ch[k]), 32'd0);
    chk("A_overrun", 32'(overrun), 32'd0);

    // Round-robin: all channels div=16, counters released together
    do_reset();
    resp_delay = 1; resp_en = 1'b1;
    for (int c = 0; c < NCH; c++) cfg_write(c, 16);
    start_en(e0);
    goto(e0 + 46);
    enable = 1'b0;
    wait_idle("B_idle", 20);
    chk("B_nstart", st_cyc.size(), 32'd8);
    for (int k = 0; k < st_cyc.size() && k < 8; k++) begin
      chk($sformatf("B_start%0d_cyc", k), st_cyc[k] - e0, 32'(16 + 4 * k));
      chk($sformatf("B_start%0d_ch", k), 32'(st_ch[k]), 32'(k % NCH));
    end
    chk("B_nvalid", sv_ch.size(), 32'd8);
    for (int k = 0; k < sv_ch.size() && k < 8; k++)
      chk($sformatf("B_valid%0d_ch", k), 32'(sv_ch[k]), 32'(k % NCH));
    chk("B_overrun", 32'(overrun), 32'd0);

    // Overrun: ch1 div=2 against a 10-cycle converter
    do_reset();
    resp_delay = 10; resp_en = 1'b1;
    cfg_write(1, 2);
    start_en(e0);
    goto(e0 + 4);
    chk("C_ovr_before", 32'(overrun), 32'd0);
    goto(e0 + 5);
    chk("C_ovr_set", 32'(overrun), 32'h2);
    goto(e0 + 12);
    chk("C_ovr_sticky", 32'(overrun), 32'h2);
    enable = 1'b0;
    @(negedge clk_in);
    clear_flags = 1'b1;
    @(negedge clk_in);
    clear_flags = 1'b0;
    chk("C_ovr_cleared", 32'(overrun), 32'd0);
    enable = 1'b1;
    goto(e0 + 15);
    chk("C_grant_tick_no_ovr", 32'(overrun), 32'd0);
    goto(e0 + 17);
    chk("C_ovr_reset", 32'(overrun), 32'h2);

    // Timeout: no adc_done; ch0 and ch1 due together
    do_reset();
    cfg_write(0, 40);
    cfg_write(1, 40);
    start_en(e0);
    goto(e0 + 56);
    chk("D_err_before", 32'(adc_error), 32'd0);
    chk("D_busy_before", 32'(busy), 32'd1);
    goto(e0 + 57);
    chk("D_err_set", 32'(adc_error), 32'd1);
    chk("D_busy_after", 32'(busy), 32'd0);
    goto(e0 + 60);
    chk("D_nstart", st_cyc.size(), 32'd2);
    if (st_cyc.size() >= 2) begin
      chk("D_start0_cyc", st_cyc[0] - e0, 32'd40);
      chk("D_start0_ch", 32'(st_ch[0]), 32'd0);
      chk("D_start1_cyc", st_cyc[1] - e0, 32'd58);
      chk("D_start1_ch", 32'(st_ch[1]), 32'd1);
    end
    chk("D_nvalid", sv_ch.size(), 32'd0);
    clear_flags = 1'b1;
    @(negedge clk_in);
    clear_flags = 1'b0;
    chk("D_err_cleared", 32'(adc_error), 32'd0);

    // Disable/reconfigure: ch2 div=5, disabled while its conversion is in flight
    do_reset();
    resp_delay = 3; resp_en = 1'b1;
    cfg_write(2, 5);
    start_en(e0);
    goto(e0 + 12);
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = '0;
    @(negedge clk_in);
    cfg_we = 1'b0;
    goto(e0 + 40);
    chk("E_nstart", st_cyc.size(), 32'd2);
    if (st_cyc.size() >= 2) begin
      chk("E_start0_cyc", st_cyc[0] - e0, 32'd5);
      chk("E_start1_cyc", st_cyc[1] - e0, 32'd11);
      chk("E_start0_ch", 32'(st_ch[0]), 32'd2);
      chk("E_start1_ch", 32'(st_ch[1]), 32'd2);
    end
    chk("E_nvalid", sv_ch.size(), 32'd2);
    for (int k = 0; k < sv_ch.size() && k < 2; k++)
      chk($sformatf("E_valid%0d_ch", k), 32'(sv_ch[k]), 32'd2);

    // Async reset in WAIT, between clock edges
    do_reset();
    cfg_write(1, 3);
    start_en(e0);
    goto(e0 + 6);
    chk("F_busy_pre", 32'(busy), 32'd1);
    chk("F_ch_pre", 32'(adc_ch), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("F_busy_async", 32'(busy), 32'd0);
    chk("F_ch_async", 32'(adc_ch), 32'd0);
    chk("F_start_async", 32'(adc_start), 32'd0);
    @(negedge clk_in);
    enable = 1'b0;
    @(negedge clk_in);
    reset = 1'b0;
    chk("F_no_valid", sv_ch.size(), 32'd0);
    st_cyc.delete(); st_ch.delete();
    cfg_write(0, 4);
    cfg_write(3, 4);
    start_en(e1);
    goto(e1 + 6);
    chk("F_nstart", st_cyc.size(), 32'd1);
    if (st_cyc.size() >= 1) begin
      chk("F_first_ch", 32'(st_ch[0]), 32'd0);
      chk("F_first_cyc", st_cyc[0] - e1, 32'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_scheduler.md
Name: adc_sample_scheduler

Overview:
- Paces and shares one external ADC converter among NCH sensor channels.
- Each channel has a programmable sample period, counted in clk_in cycles.
- Due channels are granted round-robin. The block runs a start/done handshake with the converter, reports each completed sample with its channel tag, and flags overruns and converter timeouts.
- Sits between the configuration logic and the ADC interface in the heart-signal acquisition path.

Parameters:
NCH, 4, number of channels (2..8)
CH_W, 2, channel index width, clog2(NCH)
DIV_W, 32, period register width
TIMEOUT, 1024, max cycles in WAIT before abort

Ports:
clk_in  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
enable  in  1  1 = counters run and new grants allowed
cfg_we  in  1  one-cycle period write strobe
cfg_ch  in  CH_W  channel being configured
cfg_div  in  DIV_W  new period; 0 = channel disabled
clear_flags  in  1  clears overrun and adc_error
adc_start  out  1  one-cycle conversion request
adc_ch  out  CH_W  channel for the current conversion; stable START..WAIT
adc_done  in  1  converter completion pulse
sample_valid  out  1  one-cycle pulse: conversion complete
sample_ch  out  CH_W  channel tag, valid with sample_valid
busy  out  1  FSM not in IDLE
overrun  out  NCH  sticky per-channel missed-sample flags
adc_error  out  1  sticky timeout flag

Behaviour:
Reset values:
- All outputs 0; cnt[i]=0, div[i]=0, pending=0, state=IDLE.
- last_grant=NCH-1, so the first grant goes to channel 0.

Per-channel counters (each edge, enable=1, div[i]!=0):
- cnt[i]==div[i]-1: cnt[i]<=0 and tick[i].
- Otherwise cnt[i]<=cnt[i]+1.
- div[i]=1 ticks every cycle.
- div[i]=0: cnt[i] held at 0, no ticks.
- enable=0: counters hold, pending retained.
- Counter compare uses full DIV_W width; div-1 is never evaluated for div=0.

Pending/overrun:
- tick[i] sets pending[i].
- tick[i] while pending[i]=1 and channel i is not being granted this edge: overrun[i]<=1 (sticky); pending stays 1.
- Grant clear and tick for the same channel on the same edge: pending stays 1, no overrun.

Config write (cfg_we=1):
- div[cfg_ch]<=cfg_div, cnt[cfg_ch]<=0, pending[cfg_ch]<=0.
- Overrides any tick on that channel in the same cycle.
- An in-flight conversion on that channel completes normally.

Clear:
- clear_flags zeroes overrun and adc_error.
- A set event on the same edge wins.

FSM:
- IDLE: if enable && pending!=0, grant g = first set pending index searching from last_grant+1 upward with wrap. On that edge: adc_ch<=g, last_grant<=g, pending[g]<=0, go START.
- START: adc_start=1 for exactly this cycle; go WAIT and reset the timeout counter.
- WAIT: adc_done=1 -> sample_ch<=adc_ch, go DONE. Otherwise timeout counter increments; when it reaches TIMEOUT-1, adc_error<=1 and go IDLE with no sample_valid.
- DONE: sample_valid=1 for one cycle, go IDLE.
- adc_done in IDLE, START or DONE is ignored.
- enable deasserted mid-conversion: the conversion finishes; no new grant.

Latency:
- Tick edge -> pending; next edge -> START; adc_start high the following cycle.
- Minimum spacing between adc_start pulses: 4 cycles (START, WAIT with done, DONE, IDLE).

Reset mid-operation:
- adc_start, sample_valid and busy drop immediately, asynchronously.
- No sample_valid is produced for the aborted conversion.

Test Plan:
- Period and handshake: write ch0 div=8, enable=1, converter returns adc_done 3 cycles after adc_start -> adc_start every 8 cycles with adc_ch=0, sample_valid/sample_ch=0 once per start, overrun=0.
- Round-robin: ch0..ch3 all div=16, written on the same cycle -> grants in order 0,1,2,3, repeating each period, no overrun.
- Overrun: ch1 div=2, converter holds adc_done 10 cycles -> overrun[1]=1 and stays 1. clear_flags -> 0, then sets again on the next missed tick.
- Timeout: TIMEOUT=16, adc_done never asserted -> adc_error=1 exactly 16 cycles after WAIT entry, no sample_valid, FSM returns to IDLE and serves the next pending channel.
- Disable/reconfigure: ch2 div=5 running, write ch2 div=0 -> no further ch2 grants; an in-flight ch2 conversion still yields sample_valid with sample_ch=2.
- Async reset: assert reset in WAIT, between edges -> busy and adc_ch drop to 0 immediately. After release with ch0 reprogrammed div=4, the first grant is ch0.
